// File: rtl/soc_system_pio_cmd_master.sv
// Avalon-MM initiator for a PIO-class responder.
// Commands (write / read / pulse / no-op) arrive on a valid/ready stream and are
// buffered in a small FIFO. A single FSM issues one bus cycle at a time. Only
// reads produce a response. All bus and response outputs come straight from
// registers.
module soc_system_pio_cmd_master #(
  parameter int DEPTH        = 4,   // FIFO entries, power of two, >= 2
  parameter int PULSE_CYCLES = 16,  // idle cycles between pulse assert and deassert writes
  parameter int READ_LATENCY = 0    // cycles after the read cycle before readdata is sampled
) (
  input  logic        clk,
  input  logic        reset_n,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_address,
  input  logic [31:0] cmd_data,
  // read response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  // status
  output logic        busy,
  // Avalon-MM initiator
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (PULSE_CYCLES > READ_LATENCY) ? PULSE_CYCLES : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD    = (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;
  localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_PULSE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_RESP,
    ST_P_HI,
    ST_P_WAIT,
    ST_P_LO
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO: {op, address, data}
  // ---------------------------------------------------------------------------
  logic [35:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [35:0]   head;
  logic [1:0]    head_op;
  logic [1:0]    head_addr;
  logic [31:0]   head_data;

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);
  assign push       = cmd_valid & ~fifo_full;
  assign head       = fifo_mem[rd_ptr_reg];
  assign head_op    = head[35:34];
  assign head_addr  = head[33:32];
  assign head_data  = head[31:0];

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_address, cmd_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus sequencer
  // ---------------------------------------------------------------------------
  state_t            state_reg,      state_next;
  logic [CNT_W-1:0]  cnt_reg,        cnt_next;
  logic              cs_reg,         cs_next;
  logic              write_n_reg,    write_n_next;
  logic [1:0]        address_reg,    address_next;
  logic [31:0]       writedata_reg,  writedata_next;
  logic              rsp_valid_reg,  rsp_valid_next;
  logic [31:0]       rsp_data_reg,   rsp_data_next;

  // State and registered outputs; reset drops chipselect and forgets any pending pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      cs_reg        <= 1'b0;
      write_n_reg   <= 1'b1;
      address_reg   <= '0;
      writedata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cs_reg        <= cs_next;
      write_n_reg   <= write_n_next;
      address_reg   <= address_next;
      writedata_reg <= writedata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  // Next state plus next values of the bus registers. A bus cycle is set up
  // on the transition into WR/RD/P_HI/P_LO so that chipselect is high for
  // exactly the cycle spent in that state; every other state leaves it low.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cs_next        = 1'b0;
    write_n_next   = 1'b1;
    address_next   = address_reg;
    writedata_next = writedata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    pop            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_op)
            OP_WRITE: begin
              state_next     = ST_WR;
              cs_next        = 1'b1;
              write_n_next   = 1'b0;
              address_next   = head_addr;
              writedata_next = head_data;
            end
            OP_READ: begin
              state_next   = ST_RD;
              cs_next      = 1'b1;
              address_next = head_addr;
            end
            OP_PULSE: begin
              state_next     = ST_P_HI;
              cs_next        = 1'b1;
              write_n_next   = 1'b0;
              address_next   = head_addr;
              writedata_next = head_data;
            end
            default: begin
              // no-op: consumed without a bus cycle
              state_next = ST_IDLE;
            end
          endcase
        end
      end

      ST_WR: begin
        state_next = ST_IDLE;
      end

      ST_RD: begin
        if (READ_LATENCY == 0) begin
          rsp_data_next  = readdata;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else begin
          cnt_next   = RD_LOAD;
          state_next = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // address is held, so the responder keeps presenting the selected word
        if (cnt_reg == '0) begin
          rsp_data_next  = readdata;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      ST_P_HI: begin
        cnt_next   = PULSE_LOAD;
        state_next = ST_P_WAIT;
      end

      ST_P_WAIT: begin
        if (cnt_reg == '0) begin
          state_next     = ST_P_LO;
          cs_next        = 1'b1;
          write_n_next   = 1'b0;
          writedata_next = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_P_LO: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready  = ~fifo_full;
  assign busy       = ~fifo_empty | (state_reg != ST_IDLE);
  assign chipselect = cs_reg;
  assign write_n    = write_n_reg;
  assign address    = address_reg;
  assign writedata  = writedata_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;

endmodule
